squ_circuit: RTL and testbench
==============================

// Module: squ_circuit
//
// PURPOSE
//   Sequential arithmetic/logic unit. Executes one 5-bit instruction per clock
//   on an internal accumulator and outputs one registered status bit: the odd
//   parity of the updated accumulator. Sits in the arithmetic-logic section of
//   the sequential-circuits group as a self-contained datapath+control block.
//
// PARAMETERS
//   ACC_W   8   accumulator width in bits (>= 4); all arithmetic is modulo 2**ACC_W
//
// PORTS
//   clk     in   1   single clock; all state updates on its rising edge
//   reset   in   1   synchronous, active-high reset
//   d_in    in   5   instruction: [4:3] opcode, [2:0] unsigned operand (0..7)
//   d_out   out  1   registered odd parity of the accumulator
//
// BEHAVIOUR
//   - One clock (clk). Reset is synchronous and active-high. reset=1 at a
//     rising edge sets acc<=0 and d_out<=0. d_in is ignored on that edge.
//   - Every non-reset edge executes exactly one instruction. There is no
//     valid/handshake. ADD 0 (d_in=5'b00000) acts as the NOP.
//   - op = d_in[2:0], zero-extended to ACC_W. acc_nxt is computed as follows:
//       00 ADD : acc + op        (carry discarded, wraps modulo 2**ACC_W)
//       01 SUB : acc - op        (borrow discarded, wraps; 0-1 gives all-ones)
//       10 XOR : acc ^ op        (only the low 3 bits can change)
//       11 ROL : acc rotated left by (op mod ACC_W); op=0 leaves acc unchanged
//   - On the same edge: acc<=acc_nxt and d_out<=^acc_nxt.
//   - Latency is 1 cycle. d_out reflects the instruction sampled at edge N and
//     is valid just after edge N. It holds until the next edge.
//   - The output is purely registered, with no combinational path from d_in to d_out.
//   - Reset mid-stream discards the instruction present on that edge. The next
//     edge after reset deasserts executes normally from acc=0.
//   - X/Z on d_in is not handled; the driver must keep d_in known outside reset.
//   - acc is internal; the bench reads it hierarchically as circuit.acc.
//
// STRUCTURE
//   - Shared package squ_pkg holds the opcode constants OP_ADD=2'b00,
//     OP_SUB=2'b01, OP_XOR=2'b10, OP_ROL=2'b11 and the field positions
//     OPC_MSB=4, OPC_LSB=3, OPND_MSB=2.
//   - Sub-module squ_alu (combinational) takes (acc, opcode, operand) and
//     returns acc_nxt. The top holds the acc and d_out registers, the reset
//     mux and the parity reduction.
//
// TESTING (ACC_W=8; each step is one clk edge; reset=0 unless stated)
//   1 Reset: reset=1 for one edge with any d_in -> acc=8'h00, d_out=0.
//   2 ADD: from reset, 00101 -> acc=8'h05, d_out=0; then 00010 -> acc=8'h07,
//     d_out=1.
//   3 SUB wrap: from reset, 01001 -> acc=8'hFF, d_out=0; then 00001 ->
//     acc=8'h00, d_out=0.
//   4 XOR: from reset, 00111 -> 8'h07, d_out=1; then 10011 -> 8'h04, d_out=1;
//     then 10100 -> 8'h00, d_out=0.
//   5 ROL wrap: from reset, 00001 -> 8'h01; then 11111 -> 8'h80, d_out=1;
//     then 11001 -> 8'h01, d_out=1; then 11000 -> 8'h01 (unchanged).
//   6 Reset mid-stream: acc=8'h07, then reset=1 with d_in=00111 -> acc=8'h00,
//     d_out=0; then reset=0 with d_in=00011 -> acc=8'h03, d_out=0.

Source files
------------

// File: rtl/squ_pkg.sv
// Purpose: shared opcode encodings and instruction field positions for the squ datapath.
// Latency: n/a (constants only).
// Backpressure: n/a (no flow control; every instruction is consumed).
package squ_pkg;

    // Instruction layout: d_in[OPC_MSB:OPC_LSB] = opcode, d_in[OPND_MSB:0] = operand
    localparam int OPC_MSB  = 4;
    localparam int OPC_LSB  = 3;
    localparam int OPND_MSB = 2;

    typedef logic [OPC_MSB-OPC_LSB:0] opcode_t;
    typedef logic [OPND_MSB:0]        operand_t;

    localparam opcode_t OP_ADD = 2'b00;
    localparam opcode_t OP_SUB = 2'b01;
    localparam opcode_t OP_XOR = 2'b10;
    localparam opcode_t OP_ROL = 2'b11;

endpackage

// File: rtl/squ_alu.sv
// Purpose: combinational next-accumulator calculation (ADD/SUB/XOR/ROL on a small operand).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the result is valid whenever its inputs are.
//
// Ports:
//   acc      current accumulator value
//   opcode   operation select (OP_ADD/OP_SUB/OP_XOR/OP_ROL)
//   operand  3-bit unsigned operand, zero-extended to ACC_W
//   acc_nxt  accumulator value after the operation
module squ_alu
    import squ_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] acc,
    input  opcode_t          opcode,
    input  operand_t         operand,
    output logic [ACC_W-1:0] acc_nxt
);

    logic [ACC_W-1:0] opnd_ext;
    int unsigned      rot_amt;

    always_comb begin
        opnd_ext = ACC_W'(operand);
        // Rotate amount wraps at the accumulator width; a shift by ACC_W
        // yields zero, so rot_amt=0 collapses to acc | 0 = acc.
        rot_amt  = int'(operand) % ACC_W;
        acc_nxt  = acc;
        case (opcode)
            OP_ADD:  acc_nxt = acc + opnd_ext;
            OP_SUB:  acc_nxt = acc - opnd_ext;
            OP_XOR:  acc_nxt = acc ^ opnd_ext;
            OP_ROL:  acc_nxt = (acc << rot_amt) | (acc >> (ACC_W - rot_amt));
            default: acc_nxt = acc;
        endcase
    end

endmodule

// File: rtl/squ_circuit.sv
// Purpose: sequential ALU executing one 5-bit instruction per clock on an internal accumulator.
// Latency: 1 cycle; d_out is the odd parity of the accumulator updated at the previous edge.
// Backpressure: none; every non-reset edge consumes d_in unconditionally.
//
// Ports:
//   clk    rising-edge clock for all state
//   reset  synchronous active-high reset; clears acc and d_out, discards d_in
//   d_in   instruction: [4:3] opcode, [2:0] unsigned operand (00000 = NOP)
//   d_out  registered odd parity of acc
module squ_circuit
    import squ_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_in,
    output logic       d_out
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    opcode_t          opcode;
    operand_t         operand;

    assign opcode  = d_in[OPC_MSB:OPC_LSB];
    assign operand = d_in[OPND_MSB:0];

    squ_alu #(
        .ACC_W (ACC_W)
    ) u_alu (
        .acc     (acc),
        .opcode  (opcode),
        .operand (operand),
        .acc_nxt (acc_nxt)
    );

    // Parity is taken from acc_nxt so d_out lines up with acc on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            d_out <= 1'b0;
        end else begin
            acc   <= acc_nxt;
            d_out <= ^acc_nxt;
        end
    end

endmodule

// File: tb/tb_squ_circuit.sv
// Purpose: self-checking bench for squ_circuit: directed scenarios plus randomized stream vs. a reference model.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: n/a (DUT has no handshake).
module tb_squ_circuit;

    logic       clk;
    logic       reset;
    logic [4:0] d_in;
    logic       d_out;

    int n_cmp;
    int n_bad;
    int m_acc;   // reference accumulator value

    squ_circuit #(.ACC_W(8)) circuit (
        .clk   (clk),
        .reset (reset),
        .d_in  (d_in),
        .d_out (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour written as plain integer arithmetic on 0..255.
    function automatic int model_next(input int a, input logic [4:0] d);
        int op;
        int k;
        op = int'(d[2:0]);
        case (d[4:3])
            2'd0:    return (a + op) % 256;
            2'd1:    return (a - op + 256) % 256;
            2'd2:    return a ^ op;
            default: begin
                k = op % 8;
                return ((a * (1 << k)) + (a / (1 << (8 - k)))) % 256;
            end
        endcase
    endfunction

    function automatic logic model_parity(input int a);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += (a >> i) & 1;
        return logic'(ones % 2);
    endfunction

    // Drive one edge's worth of stimulus and advance the reference model.
    task automatic apply(input logic r, input logic [4:0] d);
        @(negedge clk);
        reset = r;
        d_in  = d;
        @(posedge clk);
        #1;
        if (r) m_acc = 0;
        else   m_acc = model_next(m_acc, d);
    endtask

    task automatic test_reset();
        logic [4:0] junk;
        junk = 5'($urandom_range(0, 31));
        apply(1'b1, junk);
        apply(1'b1, 5'b00111);
        n_cmp++;
        if (circuit.acc !== 8'h00 || d_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_init: acc=%h d_out=%b, expected acc=00 d_out=0", circuit.acc, d_out);
        end
        apply(1'b0, 5'b00111);
        n_cmp++;
        if (circuit.acc !== 8'h07 || d_out !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release: acc=%h d_out=%b, expected acc=07 d_out=1", circuit.acc, d_out);
        end
        apply(1'b1, 5'b11111);
        n_cmp++;
        if (circuit.acc !== 8'h00 || d_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_clear: acc=%h d_out=%b, expected acc=00 d_out=0", circuit.acc, d_out);
        end
    endtask

    task automatic test_add();
        logic [4:0] ins [2] = '{5'b00101, 5'b00010};
        logic [7:0] ea  [2] = '{8'h05, 8'h07};
        logic       eo  [2] = '{1'b0, 1'b1};
        apply(1'b1, 5'b00000);
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, ins[i]);
            n_cmp++;
            if (circuit.acc !== ea[i] || d_out !== eo[i]) begin
                n_bad++;
                $display("FAIL add_step%0d: acc=%h d_out=%b, expected acc=%h d_out=%b", i, circuit.acc, d_out, ea[i], eo[i]);
            end
        end
    endtask

    task automatic test_sub_wrap();
        logic [4:0] ins [2] = '{5'b01001, 5'b00001};
        logic [7:0] ea  [2] = '{8'hFF, 8'h00};
        logic       eo  [2] = '{1'b0, 1'b0};
        apply(1'b1, 5'b00000);
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, ins[i]);
            n_cmp++;
            if (circuit.acc !== ea[i] || d_out !== eo[i]) begin
                n_bad++;
                $display("FAIL sub_step%0d: acc=%h d_out=%b, expected acc=%h d_out=%b", i, circuit.acc, d_out, ea[i], eo[i]);
            end
        end
    endtask

    task automatic test_xor();
        logic [4:0] ins [3] = '{5'b00111, 5'b10011, 5'b10100};
        logic [7:0] ea  [3] = '{8'h07, 8'h04, 8'h00};
        logic       eo  [3] = '{1'b1, 1'b1, 1'b0};
        apply(1'b1, 5'b00000);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, ins[i]);
            n_cmp++;
            if (circuit.acc !== ea[i] || d_out !== eo[i]) begin
                n_bad++;
                $display("FAIL xor_step%0d: acc=%h d_out=%b, expected acc=%h d_out=%b", i, circuit.acc, d_out, ea[i], eo[i]);
            end
        end
    endtask

    task automatic test_rol();
        logic [4:0] ins [4] = '{5'b00001, 5'b11111, 5'b11001, 5'b11000};
        logic [7:0] ea  [4] = '{8'h01, 8'h80, 8'h01, 8'h01};
        logic       eo  [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        apply(1'b1, 5'b00000);
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, ins[i]);
            n_cmp++;
            if (circuit.acc !== ea[i] || d_out !== eo[i]) begin
                n_bad++;
                $display("FAIL rol_step%0d: acc=%h d_out=%b, expected acc=%h d_out=%b", i, circuit.acc, d_out, ea[i], eo[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic       rs  [3] = '{1'b0, 1'b1, 1'b0};
        logic [4:0] ins [3] = '{5'b00111, 5'b00111, 5'b00011};
        logic [7:0] ea  [3] = '{8'h07, 8'h00, 8'h03};
        logic       eo  [3] = '{1'b1, 1'b0, 1'b0};
        apply(1'b1, 5'b00000);
        for (int i = 0; i < 3; i++) begin
            apply(rs[i], ins[i]);
            n_cmp++;
            if (circuit.acc !== ea[i] || d_out !== eo[i]) begin
                n_bad++;
                $display("FAIL reset_mid_step%0d: acc=%h d_out=%b, expected acc=%h d_out=%b", i, circuit.acc, d_out, ea[i], eo[i]);
            end
        end
    endtask

    // Back-to-back random instructions with occasional resets, checked every edge.
    task automatic test_random();
        logic       r;
        logic [4:0] d;
        apply(1'b1, 5'b00000);
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 24) == 0);
            d = 5'($urandom_range(0, 31));
            apply(r, d);
            n_cmp++;
            if (circuit.acc !== 8'(m_acc) || d_out !== model_parity(m_acc)) begin
                n_bad++;
                $display("FAIL random_step%0d (reset=%b d_in=%b): acc=%h d_out=%b, expected acc=%h d_out=%b",
                         i, r, d, circuit.acc, d_out, 8'(m_acc), model_parity(m_acc));
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_acc = 0;
        reset = 1'b1;
        d_in  = 5'b00000;
        test_reset();
        test_add();
        test_sub_wrap();
        test_xor();
        test_rol();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
